// File: rtl/wb8_pkg.sv
// wb8_pkg
// Shared definitions for the byte-wide Wishbone initiator wb8_master:
//   - I_size encodings for byte, half-word and word requests
//   - FSM state encoding (IDLE, STROBE, GAP)
//   - default ACK wait limit used when WB8_TIMEOUT_EN is defined
//   - helper mapping a request size to the index of its last byte
package wb8_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam int TIMEOUT_CYCLES_DEFAULT = 255;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    GAP    = 2'd2
  } state_t;

  // Index of the final byte cycle for a request; the unused encoding 2'b11
  // is handled as a full word.
  function automatic logic [1:0] last_index(input logic [1:0] size);
    case (size)
      SIZE_BYTE: last_index = 2'd0;
      SIZE_HALF: last_index = 2'd1;
      SIZE_WORD: last_index = 2'd3;
      default:   last_index = 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/wb8_master.sv
// wb8_master
// Wishbone B4 classic initiator for the 8-bit peripheral bus. A 32-bit
// byte/half/word request from the CPU side is split into 1, 2 or 4
// sequential single-byte Wishbone cycles (little-endian, address I_addr+k).
// Read bytes are gathered into a zero-extended 32-bit result that is
// presented with a one-cycle O_done pulse.
//
// Build option: define WB8_TIMEOUT_EN to enable an ACK timeout of
// TIMEOUT_CYCLES wait cycles per byte; an expired wait aborts the transfer
// and reports O_err=1 with O_done. Without the macro the block waits for
// ACK_I indefinitely and O_err is constant 0.
//
// Ports:
//   CLK_I, RST_N_I     clock (rising edge), asynchronous active-low reset
//   I_req, I_we        request strobe (sampled while idle), write enable
//   I_size, I_addr     transfer size, start byte address
//   I_wdata            write data, byte k on I_wdata[8k+7:8k]
//   O_busy, O_done     transfer in progress, one-cycle completion pulse
//   O_rdata, O_err     read result (held until next O_done), timeout flag
//   ADR_O, DAT_O, WE_O Wishbone address, write data, write enable
//   STB_O, CYC_O       Wishbone strobe and cycle
//   DAT_I, ACK_I       Wishbone read data and acknowledge
module wb8_master
  import wb8_pkg::*;
`ifdef WB8_TIMEOUT_EN
  #(parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT)
`endif
  (
  input  logic        CLK_I,
  input  logic        RST_N_I,
  input  logic        I_req,
  input  logic        I_we,
  input  logic [1:0]  I_size,
  input  logic [31:0] I_addr,
  input  logic [31:0] I_wdata,
  output logic        O_busy,
  output logic        O_done,
  output logic [31:0] O_rdata,
  output logic        O_err,
  output logic [31:0] ADR_O,
  output logic [7:0]  DAT_O,
  input  logic [7:0]  DAT_I,
  output logic        WE_O,
  output logic        STB_O,
  output logic        CYC_O,
  input  logic        ACK_I
);

  state_t      state;
  logic [1:0]  byte_idx;
  logic [1:0]  last_idx;
  logic [1:0]  next_idx;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic [31:0] acc;
  logic [31:0] acc_merged;

  assign next_idx = byte_idx + 2'd1;

  // Accumulator as it will look once the current byte is acknowledged, so
  // the final byte can go straight into O_rdata on the completing edge.
  always_comb begin
    acc_merged = acc;
    if (!we_q) begin
      acc_merged[8*byte_idx +: 8] = DAT_I;
    end
  end

`ifdef WB8_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wait_cnt;
  logic        err_q;
  assign O_err = err_q;
`else
  assign O_err = 1'b0;
`endif

  // Transfer FSM. All bus and status outputs are registered here. GAP drops
  // STB_O for exactly one cycle between bytes so a registered-ACK responder
  // cannot acknowledge the previous address a second time.
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      state    <= IDLE;
      byte_idx <= 2'd0;
      last_idx <= 2'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      we_q     <= 1'b0;
      acc      <= 32'd0;
      O_busy   <= 1'b0;
      O_done   <= 1'b0;
      O_rdata  <= 32'd0;
      ADR_O    <= 32'd0;
      DAT_O    <= 8'd0;
      WE_O     <= 1'b0;
      STB_O    <= 1'b0;
      CYC_O    <= 1'b0;
`ifdef WB8_TIMEOUT_EN
      wait_cnt <= 16'd0;
      err_q    <= 1'b0;
`endif
    end else begin
      O_done <= 1'b0;
      case (state)
        IDLE: begin
          if (I_req) begin
            state    <= STROBE;
            we_q     <= I_we;
            addr_q   <= I_addr;
            wdata_q  <= I_wdata;
            last_idx <= last_index(I_size);
            byte_idx <= 2'd0;
            acc      <= 32'd0;
            ADR_O    <= I_addr;
            DAT_O    <= I_wdata[7:0];
            WE_O     <= I_we;
            STB_O    <= 1'b1;
            CYC_O    <= 1'b1;
            O_busy   <= 1'b1;
`ifdef WB8_TIMEOUT_EN
            wait_cnt <= 16'd0;
`endif
          end
        end
        STROBE: begin
          // ACK wins over a timeout expiring in the same cycle.
          if (ACK_I) begin
            acc   <= acc_merged;
            STB_O <= 1'b0;
            if (byte_idx == last_idx) begin
              state   <= IDLE;
              CYC_O   <= 1'b0;
              WE_O    <= 1'b0;
              O_busy  <= 1'b0;
              O_done  <= 1'b1;
              O_rdata <= acc_merged;
`ifdef WB8_TIMEOUT_EN
              err_q   <= 1'b0;
`endif
            end else begin
              state <= GAP;
            end
          end
`ifdef WB8_TIMEOUT_EN
          else if (wait_cnt == TIMEOUT_LAST) begin
            state   <= IDLE;
            STB_O   <= 1'b0;
            CYC_O   <= 1'b0;
            WE_O    <= 1'b0;
            O_busy  <= 1'b0;
            O_done  <= 1'b1;
            O_rdata <= acc;
            err_q   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
`endif
        end
        GAP: begin
          state    <= STROBE;
          byte_idx <= next_idx;
          ADR_O    <= addr_q + {30'd0, next_idx};
          DAT_O    <= wdata_q[8*next_idx +: 8];
          STB_O    <= 1'b1;
`ifdef WB8_TIMEOUT_EN
          wait_cnt <= 16'd0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb8_master.sv
// tb_wb8_master
// Self-checking bench for wb8_master: a table of directed transfers with
// hand-computed results, plus hand-written sequences for reset, busy-time
// requests, back-to-back requests, mid-transfer reset and (with
// WB8_TIMEOUT_EN) the ACK timeout.
module tb_wb8_master;
  import wb8_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        busy, done, err;
  logic [31:0] rdata, adr;
  logic [7:0]  dat_o, dat_i;
  logic        we_o, stb, cyc, ack;

`ifdef WB8_TIMEOUT_EN
  wb8_master #(.TIMEOUT_CYCLES(8)) dut (
`else
  wb8_master dut (
`endif
    .CLK_I(clk), .RST_N_I(rst_n), .I_req(req), .I_we(we), .I_size(size),
    .I_addr(addr), .I_wdata(wdata), .O_busy(busy), .O_done(done),
    .O_rdata(rdata), .O_err(err), .ADR_O(adr), .DAT_O(dat_o), .DAT_I(dat_i),
    .WE_O(we_o), .STB_O(stb), .CYC_O(cyc), .ACK_I(ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ack_delay;
    logic [31:0] rd_word;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_n;
  } vec_t;

  int errors = 0;
  int checks = 0;

  // Responder: acks ack_delay cycles after STB is first seen (0 = never),
  // returning successive bytes of rd_word.
  int          ack_delay = 1;
  logic [31:0] rd_word = 32'd0;
  int          wait_cnt;
  logic [1:0]  rd_idx;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack      <= 1'b0;
      wait_cnt <= 0;
      rd_idx   <= 2'd0;
      dat_i    <= 8'd0;
    end else if (cyc && stb && !ack && ack_delay != 0) begin
      if (wait_cnt >= ack_delay - 1) begin
        ack      <= 1'b1;
        wait_cnt <= 0;
        dat_i    <= rd_word[8*rd_idx +: 8];
        rd_idx   <= rd_idx + 2'd1;
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      ack      <= 1'b0;
      wait_cnt <= 0;
      if (!cyc) rd_idx <= 2'd0;
    end
  end

  // Log every completed byte cycle as seen on the bus.
  logic [31:0] log_adr [0:255];
  logic [7:0]  log_dat [0:255];
  logic        log_we  [0:255];
  int          log_n = 0;

  always @(posedge clk) begin
    if (cyc && stb && ack && log_n < 256) begin
      log_adr[log_n] <= adr;
      log_dat[log_n] <= dat_o;
      log_we[log_n]  <= we_o;
      log_n          <= log_n + 1;
    end
  end

  // Running protocol counters sampled mid-cycle.
  int          gap_cnt = 0, unstable_cnt = 0, drop_cnt = 0, stb_cnt = 0, done_cnt = 0;
  logic        prev_stb = 1'b0, prev_we = 1'b0;
  logic [31:0] prev_adr = 32'd0;
  logic [7:0]  prev_dat = 8'd0;

  always @(negedge clk) begin
    if (busy && !cyc) drop_cnt <= drop_cnt + 1;
    if (cyc && !stb) gap_cnt <= gap_cnt + 1;
    if (stb) stb_cnt <= stb_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (stb && prev_stb && (adr != prev_adr || dat_o != prev_dat || we_o != prev_we))
      unstable_cnt <= unstable_cnt + 1;
    prev_stb <= stb;
    prev_adr <= adr;
    prev_dat <= dat_o;
    prev_we  <= we_o;
  end

  int s_log, s_gap, s_unst, s_drop, s_stb;
  int got_lat;
  bit got_seen;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Issue one request at a negedge and wait (bounded) for O_done.
  task automatic applyStimulus(input vec_t v);
    ack_delay = v.ack_delay;
    rd_word   = v.rd_word;
    @(negedge clk);
    we = v.we; size = v.size; addr = v.addr; wdata = v.wdata; req = 1'b1;
    s_log = log_n; s_gap = gap_cnt; s_unst = unstable_cnt;
    s_drop = drop_cnt; s_stb = stb_cnt;
    @(negedge clk);
    req = 1'b0;
    got_lat = 1;
    got_seen = done;
    while (!got_seen && got_lat < 400) begin
      @(negedge clk);
      got_lat++;
      got_seen = done;
    end
  endtask

  task automatic checkVector(input string tag, input vec_t v);
    logic [31:0] wd;
    int exp_gap;
    wd = v.wdata;
    exp_gap = (v.exp_n > 0) ? v.exp_n - 1 : 0;
    checkOutput({tag, "_done_seen"}, 32'(got_seen), 32'd1);
    checkOutput({tag, "_latency"}, 32'(got_lat), 32'(v.exp_lat));
    checkOutput({tag, "_rdata"}, rdata, v.exp_rdata);
    checkOutput({tag, "_err"}, 32'(err), 32'(v.exp_err));
    checkOutput({tag, "_nbytes"}, 32'(log_n - s_log), 32'(v.exp_n));
    for (int k = 0; k < v.exp_n; k++) begin
      checkOutput($sformatf("%s_adr%0d", tag, k), log_adr[s_log + k], v.addr + 32'(k));
      checkOutput($sformatf("%s_we%0d", tag, k), 32'(log_we[s_log + k]), 32'(v.we));
      if (v.we)
        checkOutput($sformatf("%s_dat%0d", tag, k), 32'(log_dat[s_log + k]), 32'(wd[8*k +: 8]));
    end
    checkOutput({tag, "_gaps"}, 32'(gap_cnt - s_gap), 32'(exp_gap));
    checkOutput({tag, "_stable"}, 32'(unstable_cnt - s_unst), 32'd0);
    checkOutput({tag, "_cyc_held"}, 32'(drop_cnt - s_drop), 32'd0);
  endtask

  vec_t vecs [6];
  vec_t v;
  int   d0;

  initial begin
    vecs[0] = '{1'b1, SIZE_WORD, 32'h0000_0100, 32'hA1B2C3D4, 1, 32'h9999_9999, 32'h0000_0000, 1'b0, 12, 4};
    vecs[1] = '{1'b0, SIZE_HALF, 32'hFFFF_FFFF, 32'h0, 1, 32'h0000_3C5A, 32'h0000_3C5A, 1'b0, 6, 2};
    vecs[2] = '{1'b0, SIZE_BYTE, 32'h0000_0020, 32'h0, 4, 32'h0000_007E, 32'h0000_007E, 1'b0, 6, 1};
    vecs[3] = '{1'b0, 2'b11,     32'h0000_0040, 32'h0, 2, 32'h4433_2211, 32'h4433_2211, 1'b0, 16, 4};
    vecs[4] = '{1'b1, SIZE_HALF, 32'h0000_0003, 32'hDEADBEEF, 1, 32'h9999_9999, 32'h0000_0000, 1'b0, 6, 2};
    vecs[5] = '{1'b0, SIZE_WORD, 32'hFFFF_FFFE, 32'h0, 1, 32'h01FF_0080, 32'h01FF_0080, 1'b0, 12, 4};

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_ctrl", {26'd0, busy, done, err, we_o, stb, cyc}, 32'd0);
    checkOutput("rst_rdata", rdata, 32'd0);
    checkOutput("rst_adr", adr, 32'd0);
    checkOutput("rst_dat", 32'(dat_o), 32'd0);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
      checkVector($sformatf("vec%0d", i), vecs[i]);
    end

    // Request during busy is ignored; request on the done cycle is accepted
    ack_delay = 4;
    rd_word = 32'h0000_00C7;
    @(negedge clk);
    s_log = log_n;
    we = 1'b0; size = SIZE_BYTE; addr = 32'h200; req = 1'b1;
    @(negedge clk); req = 1'b0;
    @(negedge clk); we = 1'b1; addr = 32'h300; wdata = 32'h0000_00AA; req = 1'b1;
    @(negedge clk); req = 1'b0;
    got_lat = 3;
    got_seen = done;
    while (!got_seen && got_lat < 400) begin
      @(negedge clk);
      got_lat++;
      got_seen = done;
    end
    checkOutput("busy_done_seen", 32'(got_seen), 32'd1);
    checkOutput("busy_latency", 32'(got_lat), 32'd6);
    checkOutput("busy_rdata", rdata, 32'h0000_00C7);
    ack_delay = 1;
    we = 1'b1; size = SIZE_BYTE; addr = 32'h400; wdata = 32'h0000_005C; req = 1'b1;
    @(negedge clk); req = 1'b0;
    checkOutput("b2b_stb", 32'(stb), 32'd1);
    checkOutput("b2b_adr", adr, 32'h400);
    got_lat = 1;
    got_seen = done;
    while (!got_seen && got_lat < 400) begin
      @(negedge clk);
      got_lat++;
      got_seen = done;
    end
    checkOutput("b2b_latency", 32'(got_lat), 32'd3);
    checkOutput("busy_nbytes", 32'(log_n - s_log), 32'd2);
    checkOutput("busy_first_adr", log_adr[s_log], 32'h200);
    checkOutput("b2b_log_adr", log_adr[s_log + 1], 32'h400);
    checkOutput("b2b_log_dat", 32'(log_dat[s_log + 1]), 32'h5C);

    // Asynchronous reset in the middle of a strobe
    ack_delay = 4;
    @(negedge clk);
    we = 1'b1; size = SIZE_WORD; addr = 32'h500; wdata = 32'h1122_3344; req = 1'b1;
    @(negedge clk); req = 1'b0;
    @(negedge clk);
    checkOutput("pre_reset_stb", 32'(stb), 32'd1);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_ctrl", {26'd0, busy, done, err, we_o, stb, cyc}, 32'd0);
    checkOutput("midrst_adr", adr, 32'd0);
    checkOutput("midrst_dat", 32'(dat_o), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    v = '{1'b1, SIZE_BYTE, 32'h0000_0600, 32'h0000_00E1, 1, 32'h9999_9999, 32'h0, 1'b0, 3, 1};
    applyStimulus(v);
    checkVector("post_rst", v);

`ifdef WB8_TIMEOUT_EN
    // ACK on the limit cycle completes normally
    v = '{1'b0, SIZE_BYTE, 32'h0000_0055, 32'h0, 7, 32'h0000_006B, 32'h0000_006B, 1'b0, 9, 1};
    applyStimulus(v);
    checkVector("to_edge", v);
    checkOutput("to_edge_stb_cycles", 32'(stb_cnt - s_stb), 32'd8);
    // No ACK at all: abort after 8 wait cycles
    v = '{1'b0, SIZE_BYTE, 32'h0000_0055, 32'h0, 0, 32'h0000_00FF, 32'h0000_0000, 1'b1, 9, 0};
    applyStimulus(v);
    checkVector("to_abort", v);
    checkOutput("to_abort_stb_cycles", 32'(stb_cnt - s_stb), 32'd8);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
